// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the shared data-memory port arbiter and its users.
// Groups the fetch port (i_*), the load/store port (d_*), the memory side
// (mem_*) and the status outputs (err, busy).
//   master : arbiter view (drives acks, read data, err, busy and mem_* request)
//   slave  : environment view (drives requests, memory read data and mem_ack)
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        err;
    logic        busy;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_ack, i_rdata, d_ack, d_rdata, err, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_ack, i_rdata, d_ack, d_rdata, err, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction
// fetch and load/store traffic. One transaction at a time: grant, hold
// mem_req until mem_ack (or abort after TIMEOUT cycles), then a one-cycle
// ack (with err on timeout) to the winner.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_port_arbiter_if.master (request ports, memory port, err/busy)
// Parameters:
//   TIMEOUT - max cycles mem_req is held without mem_ack (2..255)
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state, state_nx;
    logic        last_data, last_data_nx;   // 1 = data port won the last grant
    logic        owner_data, owner_data_nx; // 1 = current transaction is load/store
    logic [7:0]  cnt, cnt_nx;
    logic        mem_req_q, mem_req_nx;
    logic        mem_we_q, mem_we_nx;
    logic [31:0] mem_addr_q, mem_addr_nx;
    logic [31:0] mem_wdata_q, mem_wdata_nx;
    logic [31:0] i_rdata_q, i_rdata_nx;
    logic [31:0] d_rdata_q, d_rdata_nx;
    logic        i_ack_q, i_ack_nx;
    logic        d_ack_q, d_ack_nx;
    logic        err_q, err_nx;
    logic        grant_data;

    // On contention the port that did not win last time gets the grant.
    assign grant_data = bus.d_req && (!bus.i_req || !last_data);

    always_comb begin
        state_nx      = state;
        last_data_nx  = last_data;
        owner_data_nx = owner_data;
        cnt_nx        = cnt;
        mem_req_nx    = mem_req_q;
        mem_we_nx     = mem_we_q;
        mem_addr_nx   = mem_addr_q;
        mem_wdata_nx  = mem_wdata_q;
        i_rdata_nx    = i_rdata_q;
        d_rdata_nx    = d_rdata_q;
        i_ack_nx      = 1'b0;
        d_ack_nx      = 1'b0;
        err_nx        = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_data_nx = grant_data;
                    last_data_nx  = grant_data;
                    mem_req_nx    = 1'b1;
                    mem_we_nx     = grant_data && bus.d_we;
                    mem_addr_nx   = grant_data ? bus.d_addr : bus.i_addr;
                    mem_wdata_nx  = grant_data ? bus.d_wdata : '0;
                    cnt_nx        = '0;
                    state_nx      = BUSY;
                end
            end
            BUSY: begin
                // mem_ack takes priority over an expiring timeout.
                if (bus.mem_ack) begin
                    mem_req_nx = 1'b0;
                    state_nx   = RESP;
                    if (owner_data) begin
                        d_ack_nx = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_nx = bus.mem_rdata;
                        end
                    end else begin
                        i_ack_nx   = 1'b1;
                        i_rdata_nx = bus.mem_rdata;
                    end
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    mem_req_nx = 1'b0;
                    err_nx     = 1'b1;
                    state_nx   = RESP;
                    if (owner_data) begin
                        d_ack_nx   = 1'b1;
                        d_rdata_nx = '0;
                    end else begin
                        i_ack_nx   = 1'b1;
                        i_rdata_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_data   <= 1'b0;
            owner_data  <= 1'b0;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            last_data   <= last_data_nx;
            owner_data  <= owner_data_nx;
            cnt         <= cnt_nx;
            mem_req_q   <= mem_req_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
            i_rdata_q   <= i_rdata_nx;
            d_rdata_q   <= d_rdata_nx;
            i_ack_q     <= i_ack_nx;
            d_ack_q     <= d_ack_nx;
            err_q       <= err_nx;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic        pend_i, pend_d;
    logic        last_d;            // data port won the previous grant
    logic [31:0] m_i_addr;
    logic        m_d_we;
    logic [31:0] m_d_addr, m_d_wdata;
    logic [31:0] m_i_rdata, m_d_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_fetch(input logic [31:0] a);
        pend_i     = 1'b1;
        m_i_addr   = a;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
    endtask

    task automatic raise_data(input logic we, input logic [31:0] a, input logic [31:0] w);
        pend_d      = 1'b1;
        m_d_we      = we;
        m_d_addr    = a;
        m_d_wdata   = w;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = w;
    endtask

    // Runs one transaction from IDLE (requests already driven). The memory
    // answers in the (lat+1)-th cycle of mem_req with rdv; lat >= TO means
    // it never answers.
    task automatic run_txn(input int unsigned lat, input logic [31:0] rdv);
        logic        wd;
        logic        terr;
        int unsigned n;
        wd     = pend_d && (!pend_i || !last_d);
        last_d = wd;
        terr   = (lat >= TO);
        n      = terr ? TO : lat + 1;
        for (int unsigned k = 0; k < n; k++) begin
            tick();
            chk1("mem_req_held", bus.mem_req, 1'b1);
            chk1("busy_held", bus.busy, 1'b1);
            chk1("mem_we", bus.mem_we, wd ? m_d_we : 1'b0);
            chk("mem_addr", bus.mem_addr, wd ? m_d_addr : m_i_addr);
            if (wd) chk("mem_wdata", bus.mem_wdata, m_d_wdata);
            chk1("i_ack_early", bus.i_ack, 1'b0);
            chk1("d_ack_early", bus.d_ack, 1'b0);
            bus.mem_ack   = (k == lat);
            bus.mem_rdata = (k == lat) ? rdv : $urandom;
        end
        tick();
        bus.mem_ack = 1'b0;
        if (wd) begin
            if (terr) m_d_rdata = '0;
            else if (!m_d_we) m_d_rdata = rdv;
        end else begin
            m_i_rdata = terr ? 32'h0 : rdv;
        end
        chk1("mem_req_drop", bus.mem_req, 1'b0);
        chk1("busy_resp", bus.busy, 1'b1);
        chk1("i_ack", bus.i_ack, !wd);
        chk1("d_ack", bus.d_ack, wd);
        chk1("err", bus.err, terr);
        chk("i_rdata", bus.i_rdata, m_i_rdata);
        chk("d_rdata", bus.d_rdata, m_d_rdata);
        if (wd) begin
            pend_d    = 1'b0;
            bus.d_req = 1'b0;
        end else begin
            pend_i    = 1'b0;
            bus.i_req = 1'b0;
        end
        // Stray mem_ack outside BUSY must be ignored.
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        tick();
        chk1("busy_idle", bus.busy, 1'b0);
        chk1("i_ack_once", bus.i_ack, 1'b0);
        chk1("d_ack_once", bus.d_ack, 1'b0);
        chk1("err_once", bus.err, 1'b0);
        chk1("mem_req_idle", bus.mem_req, 1'b0);
        chk("i_rdata_hold", bus.i_rdata, m_i_rdata);
        chk("d_rdata_hold", bus.d_rdata, m_d_rdata);
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
    endtask

    task automatic model_reset();
        pend_i    = 1'b0;
        pend_d    = 1'b0;
        last_d    = 1'b0;
        m_i_addr  = '0;
        m_d_we    = 1'b0;
        m_d_addr  = '0;
        m_d_wdata = '0;
        m_i_rdata = '0;
        m_d_rdata = '0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        model_reset();

        // Reset state
        tick();
        tick();
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_i_ack", bus.i_ack, 1'b0);
        chk1("rst_d_ack", bus.d_ack, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Contention from reset, zero-wait memory: data, fetch, data, ...
        raise_fetch(32'h0000_1000);
        raise_data(1'b0, 32'h0000_2000, 32'h0);
        for (int unsigned k = 0; k < 6; k++) begin
            run_txn(0, $urandom);
            chk1("rr_order", last_d, (k % 2) == 0);
            if (k < 4) begin
                if (last_d) raise_data(1'b0, $urandom, $urandom);
                else raise_fetch($urandom);
            end
        end

        // Single load, memory answers after 2 wait cycles
        raise_data(1'b0, 32'h0000_0100, 32'h0);
        run_txn(2, 32'hCAFE_F00D);
        chk("load_data", bus.d_rdata, 32'hCAFE_F00D);

        // Store leaves d_rdata unchanged
        raise_data(1'b1, 32'h0000_0020, 32'h1234_5678);
        run_txn(1, 32'hDEAD_BEEF);
        chk("store_keeps_rdata", bus.d_rdata, 32'hCAFE_F00D);

        // Timeout on a load, then a normal fetch
        raise_data(1'b0, 32'h0000_0300, 32'h0);
        run_txn(TO, 32'h0);
        chk("timeout_rdata", bus.d_rdata, 32'h0);
        raise_fetch(32'h0000_0400);
        run_txn(1, 32'h0BAD_F00D);

        // Ack in the last allowed cycle wins over timeout
        raise_fetch(32'h0000_0500);
        run_txn(TO - 1, 32'hA5A5_A5A5);
        chk("last_cycle_ack", bus.i_rdata, 32'hA5A5_A5A5);

        // Random traffic
        for (int unsigned it = 0; it < 40; it++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) raise_fetch($urandom);
            if (!pend_d && $urandom_range(0, 1) == 1)
                raise_data(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!pend_i && !pend_d) raise_fetch($urandom);
            run_txn($urandom_range(0, TO + 1), $urandom);
        end

        // Asynchronous reset while BUSY
        raise_data(1'b0, 32'h0000_0040, 32'h0);
        tick();
        bus.mem_ack = 1'b0;
        chk1("pre_rst_mem_req", bus.mem_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("async_mem_req", bus.mem_req, 1'b0);
        chk1("async_busy", bus.busy, 1'b0);
        chk1("async_i_ack", bus.i_ack, 1'b0);
        chk1("async_d_ack", bus.d_ack, 1'b0);
        chk("async_mem_addr", bus.mem_addr, 32'h0);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        raise_fetch(32'h0000_0600);
        raise_data(1'b0, 32'h0000_0700, 32'h0);
        run_txn(0, 32'h1111_2222);
        chk1("post_rst_data_first", last_d, 1'b1);
        run_txn(0, 32'h3333_4444);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single data-memory port between instruction fetch and load/store traffic, ahead of the memory-mapped IO decode stage. It grants one requester at a time with round-robin fairness and holds the memory request until the memory acknowledges. It returns read data and a one-cycle ack to the winner, and aborts with an error if the memory does not answer within a bounded number of cycles.

## Interface
- TIMEOUT, 16: max cycles `mem_req` is held without `mem_ack` before abort; legal range 2..255.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request, level; held with `i_addr` stable until `i_ack`.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle completion pulse for fetch.
- i_rdata  out  32  fetch data, valid with `i_ack`, held until next fetch completion.
- d_req  in  1  load/store request, level; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ack`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  load/store address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse for load/store.
- d_rdata  out  32  load data, valid with `d_ack` on loads, held otherwise.
- err  out  1  high with `i_ack`/`d_ack` when the transaction timed out.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_rdata  in  32  memory read data, sampled when `mem_ack` = 1.
- mem_ack  in  1  memory completion, may arrive any cycle `mem_req` = 1.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if exactly one req is high, grant it. If both are high, grant the port that did not win last (`last_grant`). On grant:
  - latch owner, `we` (0 for fetch), address and wdata into the `mem_*` registers;
  - set `mem_req`=1, clear the timeout counter, update `last_grant`;
  - go to BUSY.
- BUSY: `mem_*` held constant.
  - If `mem_ack`=1: capture `mem_rdata` into the owner's rdata (loads and fetches only; stores leave `d_rdata` unchanged), set `mem_req`=0, err=0, go to RESP.
  - Else if counter = TIMEOUT-1: set `mem_req`=0, err=1, owner rdata := 32'h0, go to RESP.
  - Else counter += 1 (8-bit, never wraps because TIMEOUT ≤ 255).
- RESP: owner's ack=1 and err as set, for exactly one cycle. Requests are ignored. Go to IDLE.
- `mem_ack` and timeout in the same cycle: ack wins, err=0, data captured.
- `mem_ack` while not in BUSY: ignored.
- Deasserting req before ack is a protocol violation. The arbiter completes the latched transaction regardless.
- Reset values:
  - state=IDLE, last_grant=fetch (first contention goes to data);
  - `mem_req`/`mem_we`/`i_ack`/`d_ack`/`err`/`busy`=0;
  - `mem_addr`/`mem_wdata`/`i_rdata`/`d_rdata`=0; counter=0.
- Reset mid-transaction: all of the above apply immediately (async). The outstanding memory access is abandoned and no ack is issued.

## Timing
- Req seen in IDLE at cycle N → `mem_req` high in N+1.
- `mem_ack` in cycle M → ack/rdata/err valid in M+1 (RESP) → IDLE in M+2.
- Minimum transaction: 3 cycles from req to IDLE (ack at N+2 when `mem_ack` arrives in N+1). Back-to-back throughput is one transaction per 3 cycles.
- Timeout: `mem_req` high for exactly TIMEOUT cycles, then RESP with err=1.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Single load: `d_req`, `d_addr`=0x100, memory acks after 2 cycles with 0xCAFEF00D → `mem_addr`=0x100, `mem_we`=0; `d_ack` one cycle with `d_rdata`=0xCAFEF00D, err=0; `i_ack` never pulses.
- Contention: `i_req` and `d_req` both high from reset with zero-wait memory → grants data, fetch, data, fetch…; each ack arrives 3 cycles after the previous one.
- Store: `d_we`=1, `d_addr`=0x20, `d_wdata`=0x12345678 → `mem_we`=1, `mem_wdata`=0x12345678; `d_ack` pulses; `d_rdata` keeps its previous value.
- Timeout with TIMEOUT=4: `mem_ack` held 0 → `mem_req` high exactly 4 cycles, then ack with err=1 and rdata=0; the next request proceeds normally.
- Ack on the last cycle: `mem_ack` in the TIMEOUT-th cycle with 0xA5A5A5A5 → err=0, rdata=0xA5A5A5A5.
- Reset mid-BUSY: assert rst while `mem_req`=1 → `mem_req`, busy and acks drop without waiting for a clock. After release, simultaneous requests are granted data first.
